adc_scan_sequencer: RTL
=======================

// Module: adc_scan_sequencer
// PURPOSE
//  Sequences the I2C ADC front-end (adc) over up to 4 channels in masked round-robin, replacing ad-hoc scan FSMs in top.
//  Drives adc_channel/adc_enable, tracks the adc_ready handshake, clamps negative codes to 0 and holds the latest 15-bit voltage per channel.
//  A per-conversion watchdog recovers from a stuck I2C bus.
//  Results feed PID error computation and the uart telemetry.
// PARAMETERS
//  TIMEOUT_CYCLES  2_000_000  max clk cycles from trigger to adc_ready=1 before abort (>=4)
//  OVS_LOG2        2          log2 samples averaged per channel (only with ADC_SCAN_OVERSAMPLE_EN)
// PORTS
//  clk           in   1   system clock
//  arst          in   1   async reset, active-high
//  scan_en       in   1   1 = run continuous scan
//  ch_mask       in   4   bit k=1 enables channel k
//  adc_channel   out  2   channel select to adc, stable while adc_enable=1
//  adc_enable    out  1   conversion request to adc
//  adc_data      in   16  adc result, two's complement
//  adc_ready     in   1   adc idle/result-valid flag
//  voltage_ch0..3 out 15  latest clamped result per channel
//  valid         out  4   bit k set once channel k has a stored result
//  sample_stb    out  1   one-cycle pulse when any voltage_chK updates
//  sample_ch     out  2   channel of last update
//  timeout_err   out  1   sticky, set on any watchdog abort; cleared only by arst
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, adc_enable=0, adc_channel=0, voltage_ch*=0, valid=0, sample_stb=0, sample_ch=0, timeout_err=0, cur=3.
//  FSM: IDLE -> TRIGGER -> WAIT_START -> WAIT_DONE -> TRIGGER ...
//  IDLE: if scan_en=1 and ch_mask!=0 -> TRIGGER next cycle.
//  TRIGGER: if scan_en=0 or ch_mask=0 -> IDLE, adc_enable stays 0.
//   Else cur <= first enabled channel after cur, ascending, wrapping 3->0; a single-bit mask selects the same channel again.
//   adc_channel <= that channel, adc_enable <= 1, watchdog cleared.
//  WAIT_START: wait for adc_ready=0 (conversion accepted) -> WAIT_DONE.
//  WAIT_DONE: on adc_ready=1 (same edge):
//   voltage_ch[cur] <= adc_data[15] ? 0 : adc_data[14:0].
//   valid[cur] <= 1, sample_ch <= cur, sample_stb <= 1, adc_enable <= 0 -> TRIGGER.
//   adc_enable is therefore low for exactly 1 cycle between conversions.
//  sample_stb is high exactly one cycle; all other cycles 0.
//  Watchdog: counts cycles in WAIT_START+WAIT_DONE. At count TIMEOUT_CYCLES-1: adc_enable <= 0, timeout_err <= 1, voltage/valid unchanged, no stb -> TRIGGER (next channel).
//  scan_en=0 mid-conversion: current conversion completes (stored normally) or times out; then IDLE. I2C transactions are never cut short.
//  ch_mask changes are sampled only in TRIGGER. A channel removed mid-conversion still stores its in-flight result.
//  Valid bits are not cleared by masking.
//  adc_data read only on the adc_ready rising-qualified edge in WAIT_DONE.
// CONFIGURATION
//  ADC_SCAN_OVERSAMPLE_EN defined:
//   Each channel is converted 2**OVS_LOG2 times back-to-back; clamped samples accumulate in a (15+OVS_LOG2)-bit register.
//   After the last sample: voltage_ch[cur] <= acc>>OVS_LOG2 (truncating), valid/stb as above, then the next channel.
//   A timeout discards the partial accumulation.
//  Undefined: single conversion per channel, no accumulator logic synthesized.
// TESTING
//  T1 reset: arst=1 mid-WAIT_DONE -> adc_enable=0, all voltages 0, valid=0, timeout_err=0 same cycle.
//  T2 round-robin: mask=4'b1011, model returns 16'h1234 -> channel order 0,1,3,0.
//   voltage_ch1=15'h1234, valid=4'b1011, one stb per conversion.
//  T3 clamp: adc_data=16'h8005 on ch0 -> voltage_ch0=0. adc_data=16'h7FFF -> 15'h7FFF.
//  T4 timeout: TIMEOUT_CYCLES=16, model never drops adc_ready.
//   -> adc_enable falls 15 cycles after rise, timeout_err=1, next channel triggered, no stb.
//  T5 stop: scan_en=0 during WAIT_DONE -> result stored, stb pulses, then IDLE, adc_enable stays 0.
//   mask=0 with scan_en=1 -> IDLE.
//  T6 oversample (macro on, OVS_LOG2=2): ch2 samples 100,101,102,104 -> voltage_ch2=101 after 4th, single stb.

Source files
------------

// File: rtl/adc_scan_sequencer_if.sv
// Conversion handshake between the scan sequencer (master) and the I2C ADC front-end (slave).
interface adc_scan_sequencer_if;
    logic [1:0]  adc_channel;
    logic        adc_enable;
    logic [15:0] adc_data;
    logic        adc_ready;

    modport master (output adc_channel, adc_enable, input adc_data, adc_ready);
    modport slave  (input adc_channel, adc_enable, output adc_data, adc_ready);
endinterface

// File: rtl/adc_scan_sequencer.sv
// Masked round-robin ADC scan with per-conversion watchdog and negative-code clamping.
// Optional oversampling/averaging per channel: define ADC_SCAN_OVERSAMPLE_EN.
module adc_scan_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned OVS_LOG2       = 2
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 scan_en,
    input  logic [3:0]           ch_mask,
    adc_scan_sequencer_if.master adc,
    output logic [14:0]          voltage_ch0,
    output logic [14:0]          voltage_ch1,
    output logic [14:0]          voltage_ch2,
    output logic [14:0]          voltage_ch3,
    output logic [3:0]           valid,
    output logic                 sample_stb,
    output logic [1:0]           sample_ch,
    output logic                 timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_TRIGGER, S_WAIT_START, S_WAIT_DONE} state_t;

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_cur, r_channel, r_sample_ch, w_next_ch, w_sel_ch;
    logic [WD_W-1:0]  r_wdog;
    logic             r_enable, r_stb, r_tmo;
    logic [14:0]      r_volt [4];
    logic [3:0]       r_valid;
    logic             w_run, w_launch, w_done, w_abort, w_wdog_hit, w_store;
    logic [14:0]      w_sample, w_store_val;

    assign w_run      = scan_en && (ch_mask != '0);
    assign w_sample   = adc.adc_data[15] ? '0 : adc.adc_data[14:0];
    assign w_wdog_hit = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Descending search so the nearest enabled channel after r_cur wins; i=4 wraps back to r_cur.
    always_comb begin
        w_next_ch = r_cur;
        for (int unsigned i = 4; i >= 1; i--) begin
            if (ch_mask[r_cur + 2'(i)]) w_next_ch = r_cur + 2'(i);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE:    if (w_run) w_state_nxt = S_TRIGGER;
            S_TRIGGER: begin
                w_launch    = w_run;
                w_state_nxt = w_run ? S_WAIT_START : S_IDLE;
            end
            S_WAIT_START: begin
                if (w_wdog_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_TRIGGER;
                end else if (!adc.adc_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (adc.adc_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_TRIGGER;
                end else if (w_wdog_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_TRIGGER;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef ADC_SCAN_OVERSAMPLE_EN
    localparam int unsigned ACC_W = 15 + OVS_LOG2;
    localparam int unsigned OC_W  = OVS_LOG2 + 1;

    logic [ACC_W-1:0] r_acc, w_acc_sum;
    logic [OC_W-1:0]  r_ovs_cnt;
    logic             w_ovs_last;

    assign w_acc_sum   = r_acc + ACC_W'(w_sample);
    assign w_ovs_last  = (r_ovs_cnt == OC_W'((1 << OVS_LOG2) - 1));
    assign w_sel_ch    = (r_ovs_cnt != '0) ? r_cur : w_next_ch;
    assign w_store     = w_done && w_ovs_last;
    assign w_store_val = 15'(w_acc_sum >> OVS_LOG2);

    // Partial accumulations are dropped on abort and when the scan stops.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_acc     <= '0;
            r_ovs_cnt <= '0;
        end else if (w_abort || (r_state == S_TRIGGER && !w_run)) begin
            r_acc     <= '0;
            r_ovs_cnt <= '0;
        end else if (w_done) begin
            r_acc     <= w_ovs_last ? '0 : w_acc_sum;
            r_ovs_cnt <= w_ovs_last ? '0 : r_ovs_cnt + OC_W'(1);
        end
    end
`else
    assign w_sel_ch    = w_next_ch;
    assign w_store     = w_done;
    assign w_store_val = w_sample;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cur       <= 2'd3;
            r_channel   <= '0;
            r_enable    <= 1'b0;
            r_wdog      <= '0;
            r_volt      <= '{default: '0};
            r_valid     <= '0;
            r_stb       <= 1'b0;
            r_sample_ch <= '0;
            r_tmo       <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            if (w_launch) begin
                r_cur     <= w_sel_ch;
                r_channel <= w_sel_ch;
                r_enable  <= 1'b1;
                r_wdog    <= WD_W'(1);
            end else if (r_state == S_WAIT_START || r_state == S_WAIT_DONE) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            if (w_abort) begin
                r_enable <= 1'b0;
                r_tmo    <= 1'b1;
            end
            if (w_done) r_enable <= 1'b0;
            if (w_store) begin
                r_volt[r_cur]  <= w_store_val;
                r_valid[r_cur] <= 1'b1;
                r_sample_ch    <= r_cur;
                r_stb          <= 1'b1;
            end
        end
    end

    assign adc.adc_channel = r_channel;
    assign adc.adc_enable  = r_enable;
    assign voltage_ch0     = r_volt[0];
    assign voltage_ch1     = r_volt[1];
    assign voltage_ch2     = r_volt[2];
    assign voltage_ch3     = r_volt[3];
    assign valid           = r_valid;
    assign sample_stb      = r_stb;
    assign sample_ch       = r_sample_ch;
    assign timeout_err     = r_tmo;
endmodule
